bcd_to_binary_seq: RTL

BCD_TO_BINARY_SEQ -- requirements
Module: bcd_to_binary_seq

---
 rtl/bcd_to_binary_seq_pkg.sv | 33 +++
 rtl/bcd_to_binary_seq_if.sv | 25 ++
 rtl/bcd_to_binary_seq_sub3.sv | 10 +
 rtl/bcd_to_binary_seq.sv | 105 ++++++++++
 4 files changed

// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared widths, iteration count and FSM encoding for the sequential
// 3-digit BCD to binary converter.
package bcd_to_binary_seq_pkg;

    localparam int NUM_DIGITS = 3;
    localparam int BIN_W      = 10;
    localparam int ITER_COUNT = 10;
    localparam int DIGIT_W    = 4;
    localparam int BCD_W      = NUM_DIGITS * DIGIT_W;
    localparam int WORK_W     = BCD_W + BIN_W;
    localparam int CNT_W      = 4;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when any packed 4-bit field holds a non-decimal code (A..F).
    function automatic logic bcd_has_bad_digit(input logic [BCD_W-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[i*DIGIT_W +: DIGIT_W] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Input/output handshake bundle of the BCD to binary converter.
interface bcd_to_binary_seq_if;
    import bcd_to_binary_seq_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [DIGIT_W-1:0] in_hundreds;
    logic [DIGIT_W-1:0] in_tens;
    logic [DIGIT_W-1:0] in_ones;
    logic               out_valid;
    logic               out_ready;
    logic [BIN_W-1:0]   out_bin;
    logic               out_err;

    modport master (
        output in_valid, in_hundreds, in_tens, in_ones, out_ready,
        input  in_ready, out_valid, out_bin, out_err
    );

    modport slave (
        input  in_valid, in_hundreds, in_tens, in_ones, out_ready,
        output in_ready, out_valid, out_bin, out_err
    );

endinterface

// File: rtl/bcd_to_binary_seq_sub3.sv
// Per-digit correction step of the reverse double-dabble: a shifted BCD
// field of 8 or more had a 10 shifted into it, so take 3 off to fix it.
module bcd_to_binary_seq_sub3 (
    input  logic [3:0] i_val,
    output logic [3:0] o_val
);

    assign o_val = (i_val >= 4'd8) ? (i_val - 4'd3) : i_val;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential 3-digit BCD to 10-bit binary converter: one shift/correct
// iteration per cycle over a {bcd, bin} work register, valid/ready on both sides.
module bcd_to_binary_seq
    import bcd_to_binary_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    bcd_to_binary_seq_if.slave bus
);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [WORK_W-1:0]  r_work;
    logic [WORK_W-1:0]  w_work_next;
    logic [BIN_W-1:0]   r_out_bin;
    logic [BIN_W-1:0]   w_out_bin_next;
    logic               r_out_err;
    logic               w_out_err_next;

    logic [BCD_W-1:0]   w_in_bcd;
    logic               w_in_bad;
    logic [WORK_W-1:0]  w_shifted;
    logic [WORK_W-1:0]  w_corrected;

    assign w_in_bcd  = {bus.in_hundreds, bus.in_tens, bus.in_ones};
    assign w_in_bad  = bcd_has_bad_digit(w_in_bcd);
    assign w_shifted = r_work >> 1;

    // Binary bits pass through; only the BCD fields get corrected.
    assign w_corrected[BIN_W-1:0] = w_shifted[BIN_W-1:0];

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        bcd_to_binary_seq_sub3 u_sub3 (
            .i_val (w_shifted[BIN_W + gi*DIGIT_W +: DIGIT_W]),
            .o_val (w_corrected[BIN_W + gi*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_work_next    = r_work;
        w_out_bin_next = r_out_bin;
        w_out_err_next = r_out_err;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_cnt_next  = '0;
                    w_work_next = {w_in_bcd, {BIN_W{1'b0}}};
                    if (w_in_bad) begin
                        w_state_next   = DONE;
                        w_out_bin_next = '0;
                        w_out_err_next = 1'b1;
                    end else begin
                        w_state_next = CONV;
                    end
                end
            end
            CONV: begin
                w_work_next = w_corrected;
                w_cnt_next  = r_cnt + 1'b1;
                // The last iteration's result is taken straight from the
                // correction network so DONE follows the 10th CONV edge.
                if (r_cnt == LAST_ITER) begin
                    w_state_next   = DONE;
                    w_out_bin_next = w_corrected[BIN_W-1:0];
                    w_out_err_next = 1'b0;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_work    <= '0;
            r_out_bin <= '0;
            r_out_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_work    <= w_work_next;
            r_out_bin <= w_out_bin_next;
            r_out_err <= w_out_err_next;
        end
    end

    // Handshake outputs decode the state register only.
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_bin   = r_out_bin;
    assign bus.out_err   = r_out_err;

endmodule
